// File: rtl/buzzer_sched_pkg.sv
// Shared types for the buzzer scheduler: scheduler state encodings, the
// centre-FSM state constants and the bit positions of the mistake sources.
package buzzer_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_MISTAKE  = 3'd1,
        S_SUCCESS  = 3'd2,
        S_CHIRP    = 3'd3,
        S_DETONATE = 3'd4
    } sched_state_t;

    typedef enum logic [2:0] {
        CTR_IDLE       = 3'd0,
        CTR_ARMED      = 3'd1,
        CTR_ACTIVATED  = 3'd2,
        CTR_DEFUSED    = 3'd3,
        CTR_DETONATING = 3'd4
    } ctr_state_t;

    localparam int MIS_WIRES     = 0;
    localparam int MIS_MEMORY    = 1;
    localparam int MIS_PASSWORDS = 2;
    localparam int MIS_MAZE      = 3;
    localparam int MIS_MORSE     = 4;
    localparam int MIS_N         = 5;

    function automatic logic is_pattern(input sched_state_t s);
        return (s == S_MISTAKE) || (s == S_SUCCESS) || (s == S_CHIRP);
    endfunction

endpackage

// File: rtl/buzzer_sched_if.sv
// Request and status bundle between the sound requesters and the buzzer
// scheduler; the scheduler connects through the slave modport.
interface buzzer_sched_if;
    import buzzer_sched_pkg::*;

    logic             tick_10ms;
    logic             game_en;
    logic [MIS_N-1:0] mistake_pulse;
    logic             success_pulse;
    logic             chirp_pulse;
    logic             morse_sig;
    logic             detonate;
    logic             bebe_o;
    logic [2:0]       src_o;
    logic             busy_o;

    modport master (
        output tick_10ms, game_en, mistake_pulse, success_pulse,
               chirp_pulse, morse_sig, detonate,
        input  bebe_o, src_o, busy_o
    );

    modport slave (
        input  tick_10ms, game_en, mistake_pulse, success_pulse,
               chirp_pulse, morse_sig, detonate,
        output bebe_o, src_o, busy_o
    );

endinterface

// File: rtl/buzzer_sched_pattern.sv
// Tick-driven tone pattern: a duration counter that ends the pattern and a
// phase counter that flips the tone every half-period when toggling is enabled.
module beep_pattern_gen #(
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             run,
    input  logic             restart,
    input  logic             toggle_en,
    input  logic [CNT_W-1:0] half,
    input  logic [CNT_W-1:0] len,
    output logic             tone,
    output logic             done
);
    logic [CNT_W-1:0] dur_cnt_reg;
    logic [CNT_W-1:0] ph_cnt_reg;
    logic             tone_reg;
    logic             ph_wrap;

    // done is combinational so the scheduler can leave on the very tick that
    // ends the pattern; the counters then hold instead of incrementing.
    assign done    = run & tick & (dur_cnt_reg == len - CNT_W'(1));
    assign ph_wrap = toggle_en & (ph_cnt_reg == half - CNT_W'(1));
    assign tone    = tone_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dur_cnt_reg <= '0;
            ph_cnt_reg  <= '0;
            tone_reg    <= 1'b0;
        end else if (restart) begin
            dur_cnt_reg <= '0;
            ph_cnt_reg  <= '0;
            tone_reg    <= 1'b1;
        end else if (!run) begin
            dur_cnt_reg <= '0;
            ph_cnt_reg  <= '0;
            tone_reg    <= 1'b0;
        end else if (tick && !done) begin
            dur_cnt_reg <= dur_cnt_reg + CNT_W'(1);
            if (ph_wrap) begin
                ph_cnt_reg <= '0;
                tone_reg   <= ~tone_reg;
            end else begin
                ph_cnt_reg <= ph_cnt_reg + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/buzzer_sched.sv
// Fixed-priority owner of the piezo buzzer: latches requests that arrive while
// busy, plays the granted pattern and drives a registered buzzer output.
module buzzer_sched
    import buzzer_sched_pkg::*;
#(
    parameter int BEEP_HALF     = 5,
    parameter int MISTAKE_LEN   = 150,
    parameter int SUCCESS_BEEPS = 3,
    parameter int CHIRP_LEN     = 3,
    parameter int CNT_W         = 10
) (
    input  logic          clk,
    input  logic          rst,
    buzzer_sched_if.slave bus
);
    localparam logic [CNT_W-1:0] HALF_W    = CNT_W'(BEEP_HALF);
    localparam logic [CNT_W-1:0] MIS_LEN_W = CNT_W'(MISTAKE_LEN);
    localparam logic [CNT_W-1:0] SUC_LEN_W = CNT_W'(2 * SUCCESS_BEEPS * BEEP_HALF);
    localparam logic [CNT_W-1:0] CHP_LEN_W = CNT_W'(CHIRP_LEN);

    sched_state_t     state_reg, state_next;
    logic             pend_mis_reg, pend_mis_next;
    logic             pend_suc_reg, pend_suc_next;
    logic             pend_chp_reg, pend_chp_next;
    logic             bebe_reg, bebe_next;

    logic             any_mis;
    logic             want_mis, want_suc, want_chp;
    logic             clr_all;
    logic             restart;
    logic             run;
    logic             toggle_en;
    logic [CNT_W-1:0] len_sel;
    logic             tone;
    logic             done;

    assign any_mis  = |bus.mistake_pulse;
    assign want_mis = any_mis | pend_mis_reg;
    assign want_suc = bus.success_pulse | pend_suc_reg;
    assign want_chp = bus.chirp_pulse | pend_chp_reg;
    assign clr_all  = bus.detonate | (state_reg == S_DETONATE);

    assign run       = is_pattern(state_reg);
    assign toggle_en = (state_reg != S_CHIRP);
    assign len_sel   = (state_reg == S_MISTAKE) ? MIS_LEN_W :
                       (state_reg == S_SUCCESS) ? SUC_LEN_W : CHP_LEN_W;

    beep_pattern_gen #(
        .CNT_W     (CNT_W)
    ) u_pattern (
        .clk       (clk),
        .rst       (rst),
        .tick      (bus.tick_10ms),
        .run       (run),
        .restart   (restart),
        .toggle_en (toggle_en),
        .half      (HALF_W),
        .len       (len_sel),
        .tone      (tone),
        .done      (done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= S_IDLE;
            pend_mis_reg <= 1'b0;
            pend_suc_reg <= 1'b0;
            pend_chp_reg <= 1'b0;
            bebe_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pend_mis_reg <= pend_mis_next;
            pend_suc_reg <= pend_suc_next;
            pend_chp_reg <= pend_chp_next;
            bebe_reg     <= bebe_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        restart    = 1'b0;
        if (bus.detonate) begin
            state_next = S_DETONATE;
        end else if (!bus.game_en) begin
            // Outside the active game only the success jingle may still play.
            if (state_reg == S_SUCCESS) begin
                if (done) state_next = S_IDLE;
            end else if (state_reg == S_IDLE && want_suc) begin
                state_next = S_SUCCESS;
            end else begin
                state_next = S_IDLE;
            end
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (want_mis)      state_next = S_MISTAKE;
                    else if (want_suc) state_next = S_SUCCESS;
                    else if (want_chp) state_next = S_CHIRP;
                end
                S_MISTAKE: begin
                    if (any_mis)   restart    = 1'b1;
                    else if (done) state_next = S_IDLE;
                end
                S_SUCCESS: begin
                    if (done) state_next = S_IDLE;
                end
                S_CHIRP: begin
                    if (any_mis)   state_next = S_MISTAKE;
                    else if (done) state_next = S_IDLE;
                end
                S_DETONATE: state_next = S_IDLE;
                default:    state_next = S_IDLE;
            endcase
        end
        if (is_pattern(state_next) && state_next != state_reg) restart = 1'b1;
    end

    // A latch stays clear when its pulse is consumed by an entry or retrigger.
    always_comb begin
        pend_mis_next = pend_mis_reg;
        pend_suc_next = pend_suc_reg;
        pend_chp_next = pend_chp_reg;

        if (clr_all || !bus.game_en)      pend_mis_next = 1'b0;
        else if (state_next == S_MISTAKE) pend_mis_next = 1'b0;
        else if (any_mis)                 pend_mis_next = 1'b1;

        if (clr_all)                                                  pend_suc_next = 1'b0;
        else if (state_next == S_SUCCESS && state_reg != S_SUCCESS)   pend_suc_next = 1'b0;
        else if (bus.success_pulse)                                   pend_suc_next = 1'b1;

        if (clr_all || !bus.game_en)                                  pend_chp_next = 1'b0;
        else if (state_next == S_CHIRP && state_reg != S_CHIRP)       pend_chp_next = 1'b0;
        else if (bus.chirp_pulse)                                     pend_chp_next = 1'b1;
    end

    always_comb begin
        bebe_next = 1'b0;
        if (state_reg == S_IDLE)          bebe_next = bus.game_en & bus.morse_sig;
        else if (state_reg == S_DETONATE) bebe_next = 1'b1;
        else                              bebe_next = tone;
    end

    assign bus.bebe_o = bebe_reg;
    assign bus.src_o  = state_reg;
    assign bus.busy_o = (state_reg != S_IDLE);

endmodule

// File: doc/buzzer_sched.md
Name: buzzer_sched

Overview:
Sound scheduler that owns the single piezo buzzer output and shares it between all sound requesters. Requesters are module-mistake alarms, the defuse-success jingle, the countdown chirp, the Morse-code carrier and the detonation tone. It sits between the centre FSM / puzzle modules and the buzzer pin. It arbitrates by fixed priority, latches requests that arrive while the buzzer is busy, and generates each tone pattern from the shared 10 ms tick.

Parameters:
BEEP_HALF, 5, on/off half-period of mistake and success beeps, in tick_10ms units (50 ms)
MISTAKE_LEN, 150, total mistake alarm duration in ticks (1.5 s)
SUCCESS_BEEPS, 3, number of beeps in the success jingle
CHIRP_LEN, 3, countdown chirp on-time in ticks
CNT_W, 10, width of the duration counter; must hold MISTAKE_LEN-1 and 2*SUCCESS_BEEPS*BEEP_HALF-1

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
tick_10ms  in  1  one-cycle strobe every 10 ms
game_en  in  1  level; high while the centre FSM is in ACTIVATED
mistake_pulse  in  5  one-cycle pulses: wires, memory, passwords, maze, morse mistake
success_pulse  in  1  one-cycle pulse; mission succeeded
chirp_pulse  in  1  one-cycle pulse per countdown second
morse_sig  in  1  Morse carrier level, passed through when idle
detonate  in  1  level; centre FSM in DETONATING
bebe_o  out  1  registered buzzer drive
src_o  out  3  currently granted source (state encoding)
busy_o  out  1  high when state is not S_IDLE

Behaviour:
- Reset: state=S_IDLE, all counters 0, tone=0, all pending bits 0, bebe_o=0, src_o=S_IDLE, busy_o=0.
- States and priority, highest first: S_DETONATE(4) > S_MISTAKE(1) > S_SUCCESS(2) > S_CHIRP(3) > S_IDLE(0).
- Pending latches: pend_mis sets on any mistake_pulse bit; pend_suc sets on success_pulse; pend_chp sets on chirp_pulse. A latch does not set if its pulse is consumed the same cycle by a state entry or retrigger. A latch clears when its state is entered.
- S_IDLE: chooses the highest-priority pending or same-cycle request and enters it next cycle. If there is none, bebe_o follows morse_sig when game_en=1, else 0.
- Entry to any pattern state: dur_cnt=0, ph_cnt=0, tone=1.
- Each tick_10ms in a pattern state increments dur_cnt and ph_cnt. Between ticks the counters hold.
- S_MISTAKE: when ph_cnt==BEEP_HALF-1 on a tick, ph_cnt=0 and tone toggles. Exits to S_IDLE on the tick where dur_cnt==MISTAKE_LEN-1. A new mistake_pulse restarts the counters and sets tone=1, with no pending set.
- S_SUCCESS: toggles the same way as S_MISTAKE. Exits on the tick where dur_cnt==2*SUCCESS_BEEPS*BEEP_HALF-1. Mistake pulses during this state are latched, not preemptive.
- S_CHIRP: tone=1 for CHIRP_LEN ticks, then exits. A mistake pulse aborts the chirp and enters S_MISTAKE next cycle. The aborted chirp is dropped.
- S_DETONATE: entered from any state on the cycle after detonate=1, regardless of game_en. Holds tone=1 and clears all pending bits. Returns to S_IDLE the cycle after detonate=0.
- game_en=0 and detonate=0: forced to S_IDLE next cycle, pending bits cleared, bebe_o=0. Exception: success_pulse is still accepted in this condition, because success arrives as the FSM leaves ACTIVATED.
- bebe_o is registered. It equals tone (or the idle morse_sig) with a one-cycle latency from the state/tone update.
- A tick and an exit condition in the same cycle: the exit wins and no counter increment is visible.

Decomposition:
- Shared package: state encodings (S_IDLE..S_DETONATE), the centre-FSM state constants, and the mistake bit indices.
- One sub-module, beep_pattern_gen: tick-driven duration/phase counters plus a tone toggle. It takes a restart input, half-period and length inputs, and a toggle-enable input, and produces tone and done outputs.
- The scheduler FSM and the pending latches stay in buzzer_sched.

Test Plan:
- Bench: tick every 4 clocks, game_en=1. mistake_pulse=5'b00100 from idle -> busy_o=1 and bebe_o=1 within 2 clocks; bebe_o toggles every 5 ticks; idle after 150 ticks; then bebe_o tracks morse_sig.
- Mistake at tick 40 of an alarm -> alarm restarts and lasts 150 more ticks; no second alarm afterwards.
- success_pulse during mistake -> success jingle of 3 beeps (30 ticks) starts right after the alarm ends; src_o sequence 1, 2, 0.
- chirp_pulse, then mistake 1 tick later -> chirp aborted, src_o=1, chirp not replayed.
- detonate=1 mid-mistake with pend_suc set -> bebe_o=1 constantly; detonate=0 -> S_IDLE with pending bits cleared, bebe_o=0 when game_en=0.
- rst asserted mid-success -> bebe_o=0 immediately (asynchronous); no output after release until a new request.
